hilo_muldiv: RTL

Multi-cycle multiply/divide unit that owns the architectural HI and LO registers. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from the execute stage. It computes products and quotients iteratively, one bit per cycle, and drives the stored HI/LO values back into the ALU's `HI_input`/`LO_input` and to the MFHI/MFLO writeback path. The pipeline stalls on `busy`.

---
 rtl/hilo_pkg.sv | 32 +++
 rtl/muldiv_iter.sv | 80 ++++++++
 rtl/hilo_muldiv.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_pkg
//  Description : Shared definitions for the HI/LO multiply/divide unit:
//                operand width, iteration count, operation encodings used by
//                the decoder and the FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package hilo_pkg;

    localparam int HILO_WIDTH = 32;
    localparam int HILO_ITERS = 32;

    // Operation encodings shared with the instruction decoder.
    // Codes 3'd6 and 3'd7 are unused and ignored by the unit.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } hilo_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } hilo_state_t;

endpackage : hilo_pkg
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : One-bit-per-step datapath for unsigned multiply (shift-add
//                into a 2*WIDTH accumulator) and unsigned restoring divide
//                (WIDTH+1 bit partial remainder, quotient shifted into the
//                low half of the accumulator).
//  Ports       : clk, reset    - clock, synchronous active-high reset
//                load          - capture operand magnitudes and mode
//                step          - perform one iteration
//                is_div        - mode captured on load (1 = divide)
//                a_mag, b_mag  - multiplicand/dividend, multiplier/divisor
//                product       - 2*WIDTH product
//                quotient      - WIDTH quotient
//                remainder     - WIDTH remainder
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder
);

    // Multiply: r_acc = {partial product high, multiplier shifting out}.
    // Divide  : r_acc[WIDTH-1:0] holds the dividend shifting out at the top
    //           while quotient bits shift in at the bottom.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_operand;   // multiplicand or divisor
    logic               r_is_div;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH+1:0]   w_shift;
    logic [WIDTH+1:0]   w_diff;

    // Carry out of the upper-half add is kept so the right shift folds it in.
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_operand};
    // Extra guard bit on the trial subtraction gives a clean sign bit.
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, r_operand};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_rem     <= '0;
            r_operand <= '0;
            r_is_div  <= 1'b0;
        end else if (load) begin
            r_is_div  <= is_div;
            r_operand <= is_div ? b_mag : a_mag;
            r_acc     <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            r_rem     <= '0;
        end else if (step) begin
            if (r_is_div) begin
                // Restore on a negative trial result, otherwise keep it.
                r_rem            <= w_diff[WIDTH+1] ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
                r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], ~w_diff[WIDTH+1]};
            end else if (r_acc[0]) begin
                r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            end else begin
                r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
            end
        end
    end

    assign product   = r_acc;
    assign quotient  = r_acc[WIDTH-1:0];
    assign remainder = r_rem[WIDTH-1:0];

endmodule : muldiv_iter
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv
//  Description : Multi-cycle multiply/divide unit owning the architectural
//                HI and LO registers. MULT/MULTU/DIV/DIVU take a fixed 33
//                cycles (32 iterations + sign fix-up/write); MTHI/MTLO write
//                in one cycle.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                start, op   - request valid (sampled when not busy), opcode
//                A, B        - rs / rt operands, captured at accept
//                busy        - iterative operation in flight
//                done        - one-cycle pulse, HI/LO hold the new result
//                HI, LO      - architectural HI/LO registers
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int c_cnt_w = $clog2(HILO_ITERS + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(HILO_ITERS - 1);

    hilo_state_t        r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_is_div;
    logic               r_neg_res;    // sign(A) != sign(B) on a signed op
    logic               r_neg_rem;    // A negative on a signed op
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_a_raw;      // unmodified dividend for divide by zero

    hilo_op_t           w_op;
    logic               w_is_iter;
    logic               w_is_div;
    logic               w_is_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_load;
    logic               w_step;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_op = hilo_op_t'(op);

    always_comb begin
        w_is_iter   = 1'b0;
        w_is_div    = 1'b0;
        w_is_signed = 1'b0;
        case (w_op)
            OP_MULT:  begin w_is_iter = 1'b1; w_is_signed = 1'b1; end
            OP_MULTU: begin w_is_iter = 1'b1; end
            OP_DIV:   begin w_is_iter = 1'b1; w_is_div = 1'b1; w_is_signed = 1'b1; end
            OP_DIVU:  begin w_is_iter = 1'b1; w_is_div = 1'b1; end
            default:  ;
        endcase
    end

    assign w_a_neg = w_is_signed & A[WIDTH-1];
    assign w_b_neg = w_is_signed & B[WIDTH-1];
    assign w_a_mag = w_a_neg ? (-A) : A;
    assign w_b_mag = w_b_neg ? (-B) : B;

    assign w_load = (r_state == ST_IDLE) && start && w_is_iter;
    assign w_step = (r_state == ST_CALC);

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .step      (w_step),
        .is_div    (w_is_div),
        .a_mag     (w_a_mag),
        .b_mag     (w_b_mag),
        .product   (w_prod),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Sign correction. The most-negative / -1 case needs no special path:
    // the magnitude quotient 2^(WIDTH-1) negates back onto itself.
    assign w_prod_fix = r_neg_res  ? (-w_prod) : w_prod;
    assign w_quo_fix  = r_div_zero ? {WIDTH{1'b1}} : (r_neg_res ? (-w_quo) : w_quo);
    assign w_rem_fix  = r_div_zero ? r_a_raw : (r_neg_rem ? (-w_rem) : w_rem);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_raw    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_is_iter) begin
                            r_is_div   <= w_is_div;
                            r_neg_res  <= w_a_neg ^ w_b_neg;
                            r_neg_rem  <= w_a_neg;
                            r_div_zero <= w_is_div && (B == '0);
                            r_a_raw    <= A;
                            r_cnt      <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_CALC;
                        end else if (w_op == OP_MTHI) begin
                            r_hi   <= A;
                            r_done <= 1'b1;
                        end else if (w_op == OP_MTLO) begin
                            r_lo   <= A;
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule : hilo_muldiv
`default_nettype wire
